// File: rtl/or1200_iwb_mem_slave.sv
// or1200_iwb_mem_slave
// Wishbone B3 slave answering the OR1200 instruction-side master. It holds a
// word-organised RAM/boot image, inserts a programmable number of wait states
// before the first ack, streams linear CAB bursts at one beat per cycle, and
// answers out-of-window or misaligned accesses with a one-cycle error.
module or1200_iwb_mem_slave #(
  parameter int          AW          = 12,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cab_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o
);

  localparam int Depth = 2 ** AW;
  localparam logic [3:0] WaitLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_BURST,
    S_ERR
  } state_e;

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] ptr_q;
  logic [31:0]   datOut_q;

  logic [31:0]   mem [Depth];

  logic          req;
  logic          hit;
  logic [AW-1:0] word;
  logic [AW-1:0] ptrInc;
  logic          lastWord;
  logic [31:0]   beatAdr;
  logic          beatMatch;
  logic          memWe;

  // Request decode: window hit, word index, and the address a burst beat must carry.
  assign req       = wb_cyc_i & wb_stb_i;
  assign hit       = (wb_adr_i[31:AW+2] == BASE_ADDR[31:AW+2]) && (wb_adr_i[1:0] == 2'b00);
  assign word      = wb_adr_i[AW+1:2];
  assign ptrInc    = ptr_q + 1'b1;
  assign lastWord  = (ptr_q == {AW{1'b1}});
  assign beatAdr   = {BASE_ADDR[31:AW+2], ptr_q, 2'b00};
  assign beatMatch = (state_q == S_BURST) && req && (wb_adr_i == beatAdr);
  assign memWe     = wb_we_i && ((state_q == S_ACK) || beatMatch);

  // Burst beats ack straight from the address compare so streaming needs no wait.
  assign wb_ack_o  = (state_q == S_ACK) || beatMatch;
  assign wb_err_o  = (state_q == S_ERR);
  assign wb_rty_o  = 1'b0;
  assign wb_dat_o  = datOut_q;

  // Transfer sequencer: wait-state countdown, ack/burst/error flow and read-data prefetch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      ptr_q    <= '0;
      datOut_q <= 32'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req) begin
            ptr_q <= word;
            if (!hit) begin
              state_q <= S_ERR;
            end else if (WAIT_STATES == 0) begin
              state_q  <= S_ACK;
              datOut_q <= mem[word];
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= WaitLoad;
            end
          end
        end
        S_WAIT: begin
          if (!req) begin
            state_q <= S_IDLE;
          end else if (cnt_q == 4'd0) begin
            state_q  <= S_ACK;
            datOut_q <= mem[ptr_q];
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_ACK: begin
          if (wb_cab_i && req && !lastWord) begin
            state_q  <= S_BURST;
            ptr_q    <= ptrInc;
            datOut_q <= mem[ptrInc];
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_BURST: begin
          if (beatMatch && wb_cab_i && !lastWord) begin
            ptr_q    <= ptrInc;
            datOut_q <= mem[ptrInc];
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ERR: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Byte-lane write port, committed at the edge closing an acked write beat.
  always_ff @(posedge clk_i) begin
    if (memWe) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) begin
          mem[ptr_q][8*b +: 8] <= wb_dat_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_or1200_iwb_mem_slave.sv
// tb_or1200_iwb_mem_slave
// Self-checking bench: a Wishbone master model drives single, burst, error,
// abort and reset scenarios; expected read data is queued when a read is
// driven and popped when the slave acknowledges it.
module tb_or1200_iwb_mem_slave;

  localparam int          AW     = 6;
  localparam int          WS     = 1;
  localparam int          Depth  = 1 << AW;
  localparam logic [31:0] Base   = 32'h0000_0000;
  localparam logic [31:0] WinEnd = Base + 32'(4 * Depth);

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc   = 1'b0;
  logic        stb   = 1'b0;
  logic        we    = 1'b0;
  logic        cab   = 1'b0;
  logic [31:0] adr   = 32'd0;
  logic [31:0] wdat  = 32'd0;
  logic [3:0]  sel   = 4'd0;
  logic [31:0] rdat;
  logic        ack;
  logic        err;
  logic        rty;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] model [Depth];
  logic [31:0] expQ [$];
  logic [31:0] bAdr [8];
  logic [31:0] bDat [8];

  or1200_iwb_mem_slave #(
    .AW(AW),
    .WAIT_STATES(WS),
    .BASE_ADDR(Base),
    .INIT_FILE("")
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .wb_cyc_i(cyc),
    .wb_stb_i(stb),
    .wb_adr_i(adr),
    .wb_dat_i(wdat),
    .wb_sel_i(sel),
    .wb_we_i(we),
    .wb_cab_i(cab),
    .wb_dat_o(rdat),
    .wb_ack_o(ack),
    .wb_err_o(err),
    .wb_rty_o(rty)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Safety net so the run always ends even if the slave never answers.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drives all master-side bus signals at once.
  task automatic applyStimulus(input logic c, input logic [31:0] a, input logic w,
                               input logic [3:0] s, input logic [31:0] d, input logic cb);
    cyc  = c;
    stb  = c;
    adr  = a;
    we   = w;
    sel  = s;
    wdat = d;
    cab  = cb;
  endtask

  function automatic bit inWindow(input logic [31:0] a);
    return (a >= Base) && (a < WinEnd) && (a[1:0] == 2'b00);
  endfunction

  function automatic int idxOf(input logic [31:0] a);
    logic [31:0] off;
    off = (a - Base) >> 2;
    return int'(off) % Depth;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  // Waits (bounded) for ack or err, counting negedges from the drive point.
  task automatic waitResp(input string tag, output int cycles, output bit gotAck, output bit gotErr);
    cycles = 0;
    gotAck = 1'b0;
    gotErr = 1'b0;
    while (cycles < 30 && !gotAck && !gotErr) begin
      @(negedge clk);
      cycles++;
      if (ack && err) checkOutput({tag, "_bothResp"}, 32'd1, 32'd0);
      gotAck = ack;
      gotErr = err;
    end
    if (!gotAck && !gotErr) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Checks one response beat against the window model and the scoreboard.
  task automatic checkBeat(input string tag, input logic [31:0] a, input logic w, input logic [3:0] s,
                           input logic [31:0] d, input int expLat);
    int cycles;
    bit gotAck;
    bit gotErr;
    bit h;
    logic [31:0] e;
    h = inWindow(a);
    waitResp(tag, cycles, gotAck, gotErr);
    checkOutput({tag, "_ack"}, 32'(gotAck), 32'(h));
    checkOutput({tag, "_err"}, 32'(gotErr), 32'(!h));
    checkOutput({tag, "_lat"}, 32'(cycles), 32'(expLat));
    if (h && !w && expQ.size() > 0) begin
      e = expQ.pop_front();
      if (gotAck) checkOutput({tag, "_dat"}, rdat, e);
    end
    if (h && w && gotAck) model[idxOf(a)] = merge(model[idxOf(a)], d, s);
  endtask

  // One non-burst transfer, then release and confirm the response ended.
  task automatic singleXfer(input string tag, input logic [31:0] a, input logic w,
                            input logic [3:0] s, input logic [31:0] d);
    @(posedge clk); #1;
    applyStimulus(1'b1, a, w, s, d, 1'b0);
    if (inWindow(a) && !w) expQ.push_back(model[idxOf(a)]);
    checkBeat(tag, a, w, s, d, inWindow(a) ? WS + 2 : 2);
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput({tag, "_end"}, {30'd0, ack, err}, 32'd0);
  endtask

  // CAB burst over bAdr[0..n-1]; each beat's latency comes from address continuity.
  task automatic burstXfer(input string tag, input int n, input logic w);
    logic [31:0] a;
    logic [31:0] prevAdr;
    int prevIdx;
    int expLat;
    bit h;
    prevAdr = 32'd0;
    prevIdx = 0;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      a = bAdr[i];
      h = inWindow(a);
      applyStimulus(1'b1, a, w, 4'hF, bDat[i], 1'b1);
      if (h && !w) expQ.push_back(model[idxOf(a)]);
      if (i == 0) expLat = h ? WS + 2 : 2;
      else if (h && a == prevAdr + 32'd4 && prevIdx != Depth - 1) expLat = 1;
      else if (prevIdx == Depth - 1) expLat = h ? WS + 2 : 2;
      else expLat = h ? WS + 3 : 3;
      checkBeat($sformatf("%s%0d", tag, i), a, w, 4'hF, bDat[i], expLat);
      prevAdr = a;
      prevIdx = idxOf(a);
      @(posedge clk); #1;
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput({tag, "_end"}, {30'd0, ack, err}, 32'd0);
  endtask

  // Scenario sequence.
  initial begin
    int quiet;
    int waitCnt;

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_dat", rdat, 32'd0);
    checkOutput("rst_rty", 32'(rty), 32'd0);
    rst_n = 1'b1;

    // Fill the whole window with a known pattern through single writes.
    for (int i = 0; i < Depth; i++) begin
      singleXfer("fill", Base + 32'(4 * i), 1'b1, 4'hF, 32'hC0DE_0000 | 32'(i * 17));
    end
    singleXfer("wr3", Base + 32'h0C, 1'b1, 4'hF, 32'hDEAD_BEEF);
    singleXfer("wr2", Base + 32'h08, 1'b1, 4'hF, 32'h1122_3344);
    for (int i = 0; i < 4; i++) begin
      singleXfer("wr47", Base + 32'(16 + 4 * i), 1'b1, 4'hF, 32'(i + 1));
    end

    // Single read with wait states.
    singleXfer("rd3", Base + 32'h0C, 1'b0, 4'hF, 32'd0);
    checkOutput("rd3_const", rdat, 32'hDEAD_BEEF);

    // Byte-lane write then readback.
    singleXfer("bytewr", Base + 32'h08, 1'b1, 4'b0010, 32'h0000_AB00);
    singleXfer("byterd", Base + 32'h08, 1'b0, 4'hF, 32'd0);
    checkOutput("byte_const", rdat, 32'h1122_AB44);

    // Linear burst read of words 4..7.
    for (int i = 0; i < 4; i++) bAdr[i] = Base + 32'(16 + 4 * i);
    for (int i = 0; i < 4; i++) bDat[i] = 32'd0;
    burstXfer("brd", 4, 1'b0);

    // Burst broken by a non-sequential address.
    bAdr[0] = Base + 32'h00;
    bAdr[1] = Base + 32'h04;
    bAdr[2] = Base + 32'h20;
    burstXfer("bbrk", 3, 1'b0);

    // Burst write then burst readback.
    for (int i = 0; i < 3; i++) begin
      bAdr[i] = Base + 32'(40 + 4 * i);
      bDat[i] = 32'h5A00_0000 | 32'(i * 32'h0101);
    end
    burstXfer("bwr", 3, 1'b1);
    burstXfer("bwrrd", 3, 1'b0);

    // Error responses, and errored writes must not touch memory.
    singleXfer("errEnd", WinEnd, 1'b0, 4'hF, 32'd0);
    singleXfer("errMis", Base + 32'h02, 1'b0, 4'hF, 32'd0);
    singleXfer("errWrEnd", WinEnd, 1'b1, 4'hF, 32'hFFFF_FFFF);
    singleXfer("errWrMis", Base + 32'h02, 1'b1, 4'hF, 32'hFFFF_FFFF);
    singleXfer("errChk0", Base, 1'b0, 4'hF, 32'd0);

    // Burst reaching the last word, master then steps out of the window.
    bAdr[0] = WinEnd - 32'd8;
    bAdr[1] = WinEnd - 32'd4;
    bAdr[2] = WinEnd;
    burstXfer("wrap", 3, 1'b0);

    // Write aborted during the wait state: no response, no write.
    @(posedge clk); #1;
    applyStimulus(1'b1, Base + 32'h14, 1'b1, 4'hF, 32'hBAD0_BAD0, 1'b0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
    quiet = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack || err) quiet++;
    end
    checkOutput("abort_noResp", 32'(quiet), 32'd0);
    singleXfer("abortRd", Base + 32'h14, 1'b0, 4'hF, 32'd0);

    // Reset asserted during the wait state of a read.
    singleXfer("preRst", Base + 32'h0C, 1'b0, 4'hF, 32'd0);
    @(posedge clk); #1;
    applyStimulus(1'b1, Base + 32'h04, 1'b0, 4'hF, 32'd0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rstW_ack", 32'(ack), 32'd0);
    checkOutput("rstW_err", 32'(err), 32'd0);
    checkOutput("rstW_dat", rdat, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    quiet = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack || err) quiet++;
    end
    checkOutput("rstW_quiet", 32'(quiet), 32'd0);

    // Reset asserted while a write is being acked: that write is lost.
    @(posedge clk); #1;
    applyStimulus(1'b1, Base + 32'h14, 1'b1, 4'hF, 32'h55AA_55AA, 1'b0);
    waitCnt = 0;
    do begin
      @(negedge clk);
      waitCnt++;
    end while (!ack && waitCnt < 20);
    checkOutput("rstA_sawAck", 32'(ack), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rstA_ack", 32'(ack), 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    singleXfer("rstA_rd", Base + 32'h14, 1'b0, 4'hF, 32'd0);
    checkOutput("rstA_const", rdat, 32'd2);

    checkOutput("sb_empty", 32'(expQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
